score_uart_tx: RTL and testbench

SCORE_UART_TX -- requirements
Module: score_uart_tx

---
 rtl/score_uart_tx_pkg.sv | 25 ++
 rtl/score_uart_tx_if.sv | 21 ++
 rtl/score_uart_tx_byte.sv | 65 ++++++
 rtl/score_uart_tx.sv | 98 +++++++++
 tb/tb_score_uart_tx.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/score_uart_tx_pkg.sv
// score_uart_tx_pkg -- shared types and constants for the score regfile UART dumper.
//   state_t     : top-level FSM encoding
//   CLK_HZ_DEF  : default system clock frequency (Hz)
//   BAUD_DEF    : default UART bit rate
//   calc_div()  : clocks per UART bit, rounded to nearest
package score_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_FINISH
  } state_t;

  localparam int unsigned CLK_HZ_DEF = 100_000_000;
  localparam int unsigned BAUD_DEF   = 9600;

  // Round-to-nearest integer division; 10417 at the defaults.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/score_uart_tx_if.sv
// score_uart_tx_if -- control, regfile read and serial-out bundle.
//   start   : 1-cycle dump request
//   count   : number of 12-bit entries to send
//   rd_addr : regfile read address
//   rd_data : regfile read data, valid one clk after rd_addr changes
//   tx      : 8N1 serial line, idle high
//   busy    : dump in progress
//   done    : 1-cycle completion pulse
// master = requester/regfile side, slave = dumper.
interface score_uart_tx_if;
  logic        start;
  logic [15:0] count;
  logic [15:0] rd_addr;
  logic [11:0] rd_data;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, count, rd_data, input  rd_addr, tx, busy, done);
  modport slave  (input  start, count, rd_data, output rd_addr, tx, busy, done);
endinterface

// File: rtl/score_uart_tx_byte.sv
// uart_tx_byte -- serializes one 8N1 byte, LSB first, DIV clk per bit.
//   clk, rst_n : clock, async active-low reset
//   i_go       : load i_byte and start a frame (honoured only while o_ready)
//   i_byte     : byte to send
//   o_tx       : serial line, idle high
//   o_ready    : can accept i_go this cycle
module uart_tx_byte #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_go,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_ready
);

  localparam int unsigned BW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          r_act;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;     // 0 = start, 1..8 = d0..d7, 9 = stop
  logic [8:0]    r_shift;   // stop bit parked above the data
  logic          r_tx;
  logic          w_bit_end;
  logic          w_last;

  assign w_bit_end = (r_baud == BW'(DIV - 1));
  assign w_last    = r_act && (r_bit == 4'd9) && w_bit_end;
  // Ready during the last stop-bit clk so the next frame starts with no idle gap.
  assign o_ready   = !r_act || w_last;
  assign o_tx      = r_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act   <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else if (i_go && o_ready) begin
      r_act   <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= {1'b1, i_byte};
      r_tx    <= 1'b0;
    end else if (r_act) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_act <= 1'b0;
          r_bit <= '0;
          r_tx  <= 1'b1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_baud <= r_baud + BW'(1);
      end
    end
  end

endmodule

// File: rtl/score_uart_tx.sv
// score_uart_tx -- dumps count 12-bit regfile entries over UART as HI/LO byte pairs.
//   clk, rst_n : clock, async active-low reset
//   bus        : score_uart_tx_if.slave (start/count in, rd_addr/rd_data regfile port,
//                tx serial out, busy/done status)
// Per entry: FETCH (address out), LATCH (data back), HI byte {4'h0,d[11:8]}, LO byte d[7:0].
module score_uart_tx
  import score_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF,
  parameter int unsigned BAUD   = BAUD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  score_uart_tx_if.slave    bus
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_idx;
  logic [11:0] r_hold;
  logic        r_busy;
  logic        r_done;

  logic        w_go;
  logic [7:0]  w_byte;
  logic        w_ready;
  logic        w_tx;
  logic [15:0] w_idx_nxt;

  assign w_idx_nxt = r_idx + 16'd1;

  // HI is launched in LATCH straight from rd_data (the hold register loads on the
  // same edge) so the start bit lands 3 clk after start. go is low outside
  // LATCH/SEND_HI, so the byte bus just idles at the held HI byte there.
  assign w_go   = (r_state == ST_LATCH) || ((r_state == ST_SEND_HI) && w_ready);
  assign w_byte = (r_state == ST_LATCH)   ? {4'h0, bus.rd_data[11:8]} :
                  (r_state == ST_SEND_HI) ? r_hold[7:0] :
                                            {4'h0, r_hold[11:8]};

  uart_tx_byte #(.DIV(DIV)) u_byte (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_go    (w_go),
    .i_byte  (w_byte),
    .o_tx    (w_tx),
    .o_ready (w_ready)
  );

  assign bus.tx      = w_tx;
  assign bus.rd_addr = r_idx;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // busy stays up through the done cycle; that cycle's start is dropped.
          r_busy <= 1'b0;
          if (bus.start && !r_busy) begin
            r_cnt   <= bus.count;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= (bus.count == 16'd0) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FETCH:   r_state <= ST_LATCH;
        ST_LATCH: begin
          r_hold  <= bus.rd_data;
          r_state <= ST_SEND_HI;
        end
        ST_SEND_HI: if (w_ready) r_state <= ST_SEND_LO;
        ST_SEND_LO: begin
          if (w_ready) begin
            r_idx   <= w_idx_nxt;
            r_state <= (w_idx_nxt == r_cnt) ? ST_FINISH : ST_FETCH;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_uart_tx.sv
// tb_score_uart_tx -- directed bench for score_uart_tx at CLK_HZ=16, BAUD=4 (4 clk/bit).
// Inputs driven and outputs sampled on the falling edge; regfile modelled as a
// 16-entry synchronous-read memory.
module tb_score_uart_tx;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [11:0] mem [16];

  score_uart_tx_if bus ();

  score_uart_tx #(.CLK_HZ(16), .BAUD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start; returns at mid-cycle of the first HI start-bit clk.
  task automatic start_dump(input logic [15:0] cnt);
    @(negedge clk); bus.count = cnt; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("fetch_busy", bus.busy, 1);
    chk("fetch_addr", bus.rd_addr, 0);
    chk("fetch_tx", bus.tx, 1);
    @(negedge clk);
    chk("latch_tx", bus.tx, 1);
    @(negedge clk);
  endtask

  // Entered at the first clk of the start bit, left at the first clk of the stop bit.
  // inj != 0 pulses start (count=5) while data bit inj is on the line.
  task automatic rx_frame(input logic [7:0] exp, input string tag, input int inj);
    logic [7:0] d;
    d = '0;
    chk({tag, "_start"}, bus.tx, 0);
    for (int j = 1; j <= 8; j++) begin
      repeat (4) begin @(negedge clk); bus.start = 1'b0; end
      d[j-1] = bus.tx;
      if (j == inj) begin bus.count = 16'd5; bus.start = 1'b1; end
    end
    repeat (4) begin @(negedge clk); bus.start = 1'b0; end
    chk({tag, "_data"}, d, exp);
    chk({tag, "_stop"}, bus.tx, 1);
  endtask

  task automatic entry(input logic [11:0] v, input int inj_hi);
    rx_frame({4'h0, v[11:8]}, "hi", inj_hi);
    repeat (4) @(negedge clk);   // LO start must follow with no gap
    rx_frame(v[7:0], "lo", 0);
  endtask

  task automatic gap(input logic [15:0] idx);
    repeat (4) @(negedge clk);
    chk("gap_fetch_tx", bus.tx, 1);
    chk("gap_addr", bus.rd_addr, idx);
    @(negedge clk);
    chk("gap_latch_tx", bus.tx, 1);
    chk("gap_latch_addr", bus.rd_addr, idx);
    @(negedge clk);
  endtask

  task automatic finish_chk(input bit poke);
    repeat (4) @(negedge clk);
    chk("fin_tx", bus.tx, 1);
    chk("fin_done_early", bus.done, 0);
    chk("fin_busy", bus.busy, 1);
    @(negedge clk);
    chk("done_pulse", bus.done, 1);
    if (poke) begin bus.count = 16'd2; bus.start = 1'b1; end
    @(negedge clk); bus.start = 1'b0;
    chk("done_clr", bus.done, 0);
    chk("busy_clr", bus.busy, 0);
  endtask

  task automatic idle_chk(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk(tag, {bus.tx, bus.busy, bus.done}, 3'b100);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.count = '0;

    // Reset and idle
    repeat (5) @(negedge clk);
    chk("rst_state", {bus.tx, bus.busy, bus.done, bus.rd_addr}, {1'b1, 1'b0, 1'b0, 16'h0});
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_idle", {bus.tx, bus.busy, bus.done, bus.rd_addr}, {1'b1, 1'b0, 1'b0, 16'h0});
    end

    // Single entry: bytes 0A 5C
    mem[0] = 12'hA5C;
    start_dump(16'd1);
    entry(12'hA5C, 0);
    finish_chk(1'b0);
    idle_chk(4, "idle_after_single");

    // Three entries: 00 01 / 0F FF / 08 00
    mem[0] = 12'h001; mem[1] = 12'hFFF; mem[2] = 12'h800;
    start_dump(16'd3);
    entry(12'h001, 0);
    gap(16'd1);
    entry(12'hFFF, 0);
    gap(16'd2);
    entry(12'h800, 0);
    finish_chk(1'b0);
    chk("multi_final_addr", bus.rd_addr, 16'd3);

    // count = 0: no frame, busy two clk, done two clk after start
    @(negedge clk); bus.count = 16'd0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("c0_c1", {bus.tx, bus.busy, bus.done}, 3'b110);
    @(negedge clk);
    chk("c0_c2", {bus.tx, bus.busy, bus.done}, 3'b111);
    @(negedge clk);
    chk("c0_c3", {bus.tx, bus.busy, bus.done}, 3'b100);
    idle_chk(4, "c0_idle");

    // Start while busy (mid HI byte) and on the done cycle: both ignored
    mem[0] = 12'h123;
    start_dump(16'd1);
    entry(12'h123, 3);
    finish_chk(1'b1);
    idle_chk(12, "ignored_start_idle");
    chk("ignored_addr", bus.rd_addr, 16'd1);

    // Reset during d3 of the first HI byte (0x03: d3 = 0)
    mem[0] = 12'h3C7; mem[1] = 12'hA5C;
    start_dump(16'd2);
    repeat (16) @(negedge clk);
    chk("pre_abort_d3", bus.tx, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", bus.tx, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_addr", bus.rd_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_chk(8, "abort_idle");
    start_dump(16'd2);
    entry(12'h3C7, 0);
    gap(16'd1);
    entry(12'hA5C, 0);
    finish_chk(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
